// File: rtl/serializador_if.sv
// Parallel producer / serial receiver signal bundle for serializador.
// The slave modport is the serializer's view; master is the producer/receiver side.
interface serializador_if;
    logic [7:0] data_in;
    logic       write_in;
    logic       status_out;
    logic       empty_out;
    logic       overflow_out;
    logic       data_out;
    logic       write_out;
    logic       status_in;
    logic       err_out;

    modport slave (
        input  data_in, write_in, status_in,
        output status_out, empty_out, overflow_out, data_out, write_out, err_out
    );

    modport master (
        output data_in, write_in, status_in,
        input  status_out, empty_out, overflow_out, data_out, write_out, err_out
    );
endinterface

// File: rtl/serializador.sv
// serializador: byte FIFO feeding an MSB-first bit-serial link, one busy/idle handshake per byte.
// Define SER_TIMEOUT_EN to add a watchdog on the handshake wait states (err_out pulse).
module serializador #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input logic           clk_100KHz,
    input logic           reset,
    serializador_if.slave ser
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW:0]   cnt_t;
    typedef logic [AW-1:0] ptr_t;
    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_HI, WAIT_LO} state_t;

    state_t     state_q, state_d;
    logic [7:0] mem [DEPTH];
    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    cnt_t       count_q, count_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       push, pop;
    logic [7:0] head;

    logic status_q, status_d;
    logic empty_q, empty_d;
    logic overflow_q, overflow_d;
    logic data_q, data_d;
    logic write_q, write_d;

`ifdef SER_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wait_q, wait_d, wait_inc;
    logic          wait_expired;
    logic          err_q, err_d;

    assign wait_inc     = wait_q + 1'b1;
    assign wait_expired = (wait_inc == WW'(TIMEOUT));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
`endif

    assign head = mem[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        write_d    = 1'b0;
        data_d     = 1'b0;
`ifdef SER_TIMEOUT_EN
        wait_d     = '0;
        err_d      = 1'b0;
`endif
        // The pop decision feeds the push-when-full rule, so it is resolved first.
        pop        = (state_q == IDLE) && (count_q != '0) && !ser.status_in;
        push       = ser.write_in && ((count_q != cnt_t'(DEPTH)) || pop);
        wr_ptr_d   = wr_ptr_q + ptr_t'(push);
        rd_ptr_d   = rd_ptr_q + ptr_t'(pop);
        count_d    = count_q + cnt_t'(push) - cnt_t'(pop);

        case (state_q)
            IDLE: begin
                if (pop) begin
                    // Bit 7 leaves on the pop edge; the register keeps the remaining seven.
                    write_d  = 1'b1;
                    data_d   = head[7];
                    shreg_d  = {head[6:0], 1'b0};
                    bitcnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (bitcnt_q == 3'd7) begin
                    state_d = WAIT_HI;
                end else begin
                    write_d  = 1'b1;
                    data_d   = shreg_q[7];
                    shreg_d  = {shreg_q[6:0], 1'b0};
                    bitcnt_d = bitcnt_q + 3'd1;
                end
            end
            WAIT_HI: begin
                if (ser.status_in) begin
                    state_d = WAIT_LO;
                end
`ifdef SER_TIMEOUT_EN
                else if (wait_expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_inc;
                end
`endif
            end
            WAIT_LO: begin
                if (!ser.status_in) begin
                    state_d = IDLE;
                end
`ifdef SER_TIMEOUT_EN
                else if (wait_expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_inc;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        status_d   = (count_d == cnt_t'(DEPTH));
        empty_d    = (count_d == '0) && (state_d == IDLE);
        overflow_d = ser.write_in && !push;
    end

    always_ff @(posedge clk_100KHz) begin
        if (push && !reset) begin
            mem[wr_ptr_q] <= ser.data_in;
        end
    end

    always_ff @(posedge clk_100KHz) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            status_q   <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            data_q     <= 1'b0;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            status_q   <= status_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            data_q     <= data_d;
            write_q    <= write_d;
        end
    end

`ifdef SER_TIMEOUT_EN
    always_ff @(posedge clk_100KHz) begin
        if (reset) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign ser.err_out = err_q;
`else
    assign ser.err_out = 1'b0;
`endif

    assign ser.status_out   = status_q;
    assign ser.empty_out    = empty_q;
    assign ser.overflow_out = overflow_q;
    assign ser.data_out     = data_q;
    assign ser.write_out    = write_q;
endmodule
